uart_hs_phy: RTL

- Serial PHY directly downstream of the Avalon UART wrapper; runs in the fast sys_clk domain.
- Serialises bytes onto uart_txd and deserialises uart_rxd, 8N1 format, LSB first.
- Exchanges bytes with the wrapper through two 4-phase req/ack handshakes, one per direction, so the wrapper may run on an unrelated clock.
- Every handshake input coming from the wrapper is synchronised inside this block.

---
 rtl/uart_hs_phy_if.sv | 20 ++
 rtl/uart_hs_phy.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_hs_phy_if.sv
// Byte handshake bundle between the UART wrapper (master) and the serial PHY (slave).
// Two independent 4-phase req/ack pairs: receive (PHY -> wrapper) and send (wrapper -> PHY).
interface uart_hs_phy_if;
  logic       uart_rec_req;
  logic       uart_rec_ack;
  logic [7:0] uart_data_out;
  logic       uart_send_req;
  logic       uart_send_ack;
  logic [7:0] uart_data_in;

  modport master (
    input  uart_rec_req, uart_data_out, uart_send_ack,
    output uart_rec_ack, uart_send_req, uart_data_in
  );

  modport slave (
    output uart_rec_req, uart_data_out, uart_send_ack,
    input  uart_rec_ack, uart_send_req, uart_data_in
  );
endinterface

// File: rtl/uart_hs_phy.sv
// 8N1 UART PHY with 4-phase req/ack byte handshakes toward a wrapper on an unrelated clock.
// Send ack 3 cycles after req (2 sync + 1); a busy receive handshake drops good frames (rx_overrun).
module uart_hs_phy #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         uart_rxd,
  output logic         uart_txd,
  uart_hs_phy_if.slave hs,
  output logic         rx_overrun,
  output logic         rx_frame_err
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BPS_CNT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic rxd_meta, rxd_s, rxd_d;
  logic ack_meta, ack_s;
  logic req_meta, req_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
      ack_meta <= hs.uart_rec_ack;
      ack_s    <= ack_meta;
      req_meta <= hs.uart_send_req;
      req_s    <= req_meta;
    end
  end

  state_t          rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_shift;
  logic            rx_load;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state         <= ST_IDLE;
      rx_cnt           <= '0;
      rx_idx           <= '0;
      rx_shift         <= '0;
      rx_load          <= 1'b0;
      rx_overrun       <= 1'b0;
      rx_frame_err     <= 1'b0;
      hs.uart_rec_req  <= 1'b0;
      hs.uart_data_out <= '0;
    end else begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_load      <= 1'b0;
      if (rx_load) begin
        hs.uart_data_out <= rx_shift;
        hs.uart_rec_req  <= 1'b1;
      end else if (hs.uart_rec_req && ack_s) begin
        hs.uart_rec_req  <= 1'b0;
      end
      case (rx_state)
        ST_IDLE: begin
          if (rxd_d && !rxd_s) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        end
        ST_START: begin
          // Mid-start-bit recheck filters line glitches.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= ST_STOP;
            else                rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
            if (!rxd_s)                         rx_frame_err <= 1'b1;
            else if (hs.uart_rec_req || ack_s)  rx_overrun   <= 1'b1;
            else                                rx_load      <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  state_t          tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_shift;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state         <= ST_IDLE;
      tx_cnt           <= '0;
      tx_idx           <= '0;
      tx_shift         <= '0;
      uart_txd         <= 1'b1;
      hs.uart_send_ack <= 1'b0;
    end else begin
      // Ack release follows req alone so the wrapper can re-arm mid-frame.
      if (!req_s) hs.uart_send_ack <= 1'b0;
      case (tx_state)
        ST_IDLE: begin
          uart_txd <= 1'b1;
          if (req_s && !hs.uart_send_ack) begin
            tx_shift         <= hs.uart_data_in;
            hs.uart_send_ack <= 1'b1;
            tx_state         <= ST_START;
            tx_cnt           <= '0;
            uart_txd         <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
